// File: rtl/tcdm_initiator_adapter.sv
// Adapter between a valid/ready request master and one TCDM interconnect initiator port.
// Credits cover in-flight and buffered responses, so the unstallable vld_i always finds room.
module tcdm_initiator_adapter #(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned BeWidth     = DataWidth / 8,
  parameter int unsigned RespDepth   = 4,
  parameter bit          WriteRespOn = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [AddrWidth-1:0]           in_add_i,
  input  logic                           in_wen_i,
  input  logic [DataWidth-1:0]           in_wdata_i,
  input  logic [BeWidth-1:0]             in_be_i,
  output logic                           out_rvalid_o,
  input  logic                           out_rready_i,
  output logic [DataWidth-1:0]           out_rdata_o,
  output logic                           out_we_o,
  output logic                           req_o,
  output logic [AddrWidth-1:0]           add_o,
  output logic                           wen_o,
  output logic [DataWidth-1:0]           wdata_o,
  output logic [BeWidth-1:0]             be_o,
  input  logic                           gnt_i,
  input  logic                           vld_i,
  input  logic [DataWidth-1:0]           rdata_i,
  output logic [$clog2(RespDepth+1)-1:0] outstanding_o
);

  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam int unsigned PtrW = $clog2(RespDepth);

  logic                 hold_valid_q, hold_valid_d;
  logic [AddrWidth-1:0] add_q, add_d;
  logic                 wen_q, wen_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [BeWidth-1:0]   be_q, be_d;

  logic                 tag_mem_q [RespDepth];
  logic [PtrW-1:0]      tag_wptr_q, tag_wptr_d;
  logic [PtrW-1:0]      tag_rptr_q, tag_rptr_d;
  logic [CntW-1:0]      inflight_q, inflight_d;

  logic [DataWidth-1:0] resp_data_q [RespDepth];
  logic                 resp_we_q   [RespDepth];
  logic [PtrW-1:0]      resp_wptr_q, resp_wptr_d;
  logic [PtrW-1:0]      resp_rptr_q, resp_rptr_d;
  logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;

  logic            needs_resp;
  logic            has_credit;
  logic            fire;
  logic            accept;
  logic            tag_push;
  logic            vld_ok;
  logic            resp_pop;
  logic            head_tag;
  logic [CntW-1:0] outstanding;

  // Credits only shrink on a grant, so a raised req_o cannot drop before it fires.
  assign needs_resp   = !wen_q || WriteRespOn;
  assign outstanding  = inflight_q + fifo_cnt_q;
  assign has_credit   = outstanding < CntW'(RespDepth);
  assign req_o        = hold_valid_q && (!needs_resp || has_credit);
  assign fire         = req_o && gnt_i;
  assign in_ready_o   = !hold_valid_q || fire;
  assign accept       = in_valid_i && in_ready_o;
  assign tag_push     = fire && needs_resp;
  assign vld_ok       = vld_i && (inflight_q != '0);
  assign head_tag     = tag_mem_q[tag_rptr_q];
  assign out_rvalid_o = fifo_cnt_q != '0;
  assign resp_pop     = out_rvalid_o && out_rready_i;
  assign out_rdata_o  = out_rvalid_o ? resp_data_q[resp_rptr_q] : '0;
  assign out_we_o     = out_rvalid_o && resp_we_q[resp_rptr_q];

  assign add_o         = add_q;
  assign wen_o         = wen_q;
  assign wdata_o       = wdata_q;
  assign be_o          = be_q;
  assign outstanding_o = outstanding;

  always_comb begin
    hold_valid_d = hold_valid_q;
    add_d        = add_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      add_d        = in_add_i;
      wen_d        = in_wen_i;
      wdata_d      = in_wdata_i;
      be_d         = in_be_i;
    end else if (fire) begin
      hold_valid_d = 1'b0;
    end
    tag_wptr_d  = tag_wptr_q + PtrW'(tag_push);
    tag_rptr_d  = tag_rptr_q + PtrW'(vld_ok);
    inflight_d  = inflight_q + CntW'(tag_push) - CntW'(vld_ok);
    resp_wptr_d = resp_wptr_q + PtrW'(vld_ok);
    resp_rptr_d = resp_rptr_q + PtrW'(resp_pop);
    fifo_cnt_d  = fifo_cnt_q + CntW'(vld_ok) - CntW'(resp_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      add_q        <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      be_q         <= '0;
      tag_wptr_q   <= '0;
      tag_rptr_q   <= '0;
      inflight_q   <= '0;
      resp_wptr_q  <= '0;
      resp_rptr_q  <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      add_q        <= add_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      tag_wptr_q   <= tag_wptr_d;
      tag_rptr_q   <= tag_rptr_d;
      inflight_q   <= inflight_d;
      resp_wptr_q  <= resp_wptr_d;
      resp_rptr_q  <= resp_rptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

  // Storage is not reset; validity comes from the reset counters and pointers.
  always_ff @(posedge clk_i) begin
    if (tag_push) begin
      tag_mem_q[tag_wptr_q] <= wen_q;
    end
    if (vld_ok) begin
      resp_data_q[resp_wptr_q] <= head_tag ? '0 : rdata_i;
      resp_we_q[resp_wptr_q]   <= head_tag;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && vld_i) begin
      assert (inflight_q != '0)
        else $warning("tcdm_initiator_adapter: vld_i with nothing in flight, response ignored");
    end
  end
`endif

endmodule

// File: doc/tcdm_initiator_adapter.md
# tcdm_initiator_adapter

Per-initiator adapter between a core/DMA port and one initiator port of the TCDM interconnect. It accepts requests on a valid/ready handshake and holds each one in a register. It drives the interconnect req/gnt protocol and buffers the interconnect's unstallable vld/rdata responses in a response FIFO. Credit accounting ensures a response can never be dropped, so the upstream master may backpressure responses freely.

## Interface
Parameters:
- AddrWidth, 32, byte address width; passed through unchanged.
- DataWidth, 32, data word width.
- BeWidth, DataWidth/8, byte-enable width.
- RespDepth, 4, response FIFO depth. Must be a power of 2 and ≥ 2. It is also the maximum number of outstanding responses.
- WriteRespOn, 1, set to 1 if the interconnect returns vld for writes. Must match the interconnect setting.

Ports:
- clk_i, in, 1, clock, rising edge.
- rst_i, in, 1, asynchronous active-high reset.
- in_valid_i, in, 1, upstream request valid.
- in_ready_o, out, 1, upstream request ready.
- in_add_i, in, AddrWidth, request address.
- in_wen_i, in, 1, 1 = store, 0 = load.
- in_wdata_i, in, DataWidth, write data.
- in_be_i, in, BeWidth, byte enables.
- out_rvalid_o, out, 1, response valid to upstream.
- out_rready_i, in, 1, upstream response ready.
- out_rdata_o, out, DataWidth, response data.
- out_we_o, out, 1, 1 = the response belongs to a write.
- req_o, out, 1, interconnect request.
- add_o, out, AddrWidth, interconnect address.
- wen_o, out, 1, interconnect write enable.
- wdata_o, out, DataWidth, interconnect write data.
- be_o, out, BeWidth, interconnect byte enables.
- gnt_i, in, 1, interconnect grant; combinational on req_o.
- vld_i, in, 1, interconnect response valid; cannot be stalled.
- rdata_i, in, DataWidth, interconnect read data.
- outstanding_o, out, $clog2(RespDepth+1), count of granted responses not yet popped upstream.

## Operation
- **Hold register.** One entry: hold_valid plus {add, wen, wdata, be}.
  - It loads on in_valid_i && in_ready_o.
  - add_o, wen_o, wdata_o and be_o drive directly from the register.
- **Response-generating request (needs_resp).** A request is needs_resp when wen = 0, or when WriteRespOn = 1.
- **Credits.** credits = RespDepth − outstanding. outstanding = inflight + fifo_count.
- **Request issue.** req_o = hold_valid && (!needs_resp || credits > 0).
  - fire = req_o && gnt_i.
  - Once asserted, req_o and its payload stay stable until fire.
- **Upstream ready.** in_ready_o = !hold_valid || fire.
  - gnt_i reaches in_ready_o combinationally; this path is intentional.
  - On fire with in_valid_i high, the register reloads in the same edge (back-to-back issue).
- **In-flight tag FIFO.** Depth RespDepth, 1-bit tags.
  - On fire of a needs_resp request, wen is pushed and inflight increments.
  - On vld_i, the head tag is popped and inflight decrements.
  - Responses return in order.
- **Response FIFO.** Depth RespDepth, entries {rdata, we}.
  - On vld_i, it pushes {rdata_i, popped tag}.
  - When the tag is a write, rdata is stored as 0.
  - Pops on out_rvalid_o && out_rready_i.
  - Credits guarantee there is always space. No fall-through: out_rvalid_o = fifo non-empty.
- **Simultaneous events.**
  - Same-cycle fire, vld_i and pop update all counters consistently: outstanding += fire_needs_resp − pop.
  - Same-cycle FIFO push and pop at full or empty are legal.
- **Errors.** vld_i while inflight = 0 is a protocol error.
  - The response is ignored: no push, counters unchanged.
  - A simulation assertion fires.
  - Pointers wrap modulo RespDepth.

## Timing
- **Reset values.** Reset asynchronously clears:
  - hold_valid, req_o, add_o, wen_o, wdata_o and be_o to 0;
  - both FIFOs to empty, inflight to 0, out_rvalid_o to 0;
  - out_rdata_o and out_we_o to 0;
  - outstanding_o to 0.
  - in_ready_o is 1 in reset.
- **Latency.**
  - An upstream accept at edge N gives req_o high in cycle N+1.
  - vld_i sampled at edge M gives out_rvalid_o high in cycle M+1.
  - Minimum load turnaround (accept to rvalid) is 2 + interconnect MemLatency cycles.
- **Throughput.** One request per cycle with continuous gnt_i, provided credits do not limit. Sustaining it needs RespDepth ≥ MemLatency + 2.
- **Credit stall.** When outstanding_o = RespDepth:
  - req_o is low for a needs_resp request;
  - it rises in the cycle after an upstream pop.
- **Reset mid-operation.** All state is discarded. vld_i arriving after reset for pre-reset grants is treated as a protocol error and ignored.

## Test plan
- **Single load.** Reset; send load add=0x100. Model gnt_i=1 and vld_i one cycle after fire with rdata_i=0xDEADBEEF → out_rvalid_o=1, out_rdata_o=0xDEADBEEF, out_we_o=0; outstanding_o goes 1→0 on pop.
- **Grant stall.** Hold gnt_i=0 for 5 cycles → req_o, add_o and wdata_o stay constant and in_ready_o=0. Assert gnt_i → in_ready_o=1 in the same cycle; a second request issues in the next cycle.
- **Credit exhaustion.** RespDepth=4, out_rready_i=0; issue 6 loads → exactly 4 fires and outstanding_o=4, req_o low. Pop one → the fifth load fires in the following cycle.
- **Write responses.**
  - WriteRespOn=1: a store produces out_we_o=1 with out_rdata_o=0.
  - WriteRespOn=0: 8 stores with out_rready_i=0 all fire and outstanding_o stays 0.
- **Simultaneous events.** FIFO at 3 entries; assert fire, vld_i and pop in the same cycle → outstanding_o unchanged, ordering preserved. Compare against a 200-transaction random in-order scoreboard.
- **Reset mid-flight.** Apply rst_i with 2 in flight → all outputs at reset values. A post-reset vld_i is ignored, out_rvalid_o stays 0, and the assertion fires.
